atm_pin_account_unit: RTL and testbench

- Account/PIN stage directly upstream of the ATM control FSM.
- Holds a small account table (PIN, balance, optional lock state).
- Collects serially entered PIN digits for the inserted card, compares them and produces the FSM's wrong_psw result pulse and current_balance.
- Commits the FSM's updated balance back to the table at session end.

---
 rtl/atm_pkg.sv | 23 ++
 rtl/atm_account_table.sv | 86 ++++++++
 rtl/atm_pin_account_unit.sv | 158 +++++++++++++++
 tb/tb_atm_pin_account_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM PIN/account stage and the downstream control FSM.
package atm_pkg;

  localparam int BALANCE_W_DEFAULT = 20;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_COMPARE = 3'd2,
    ST_RESULT  = 3'd3,
    ST_SESSION = 3'd4
  } pin_state_t;

  // Transaction codes understood by the control FSM.
  typedef enum logic [1:0] {
    OP_BALANCE  = 2'd0,
    OP_DEPOSIT  = 2'd1,
    OP_WITHDRAW = 2'd2,
    OP_EXIT     = 2'd3
  } atm_op_t;

endpackage

// File: rtl/atm_account_table.sv
// Account table: PIN and balance per entry, one write port, one async read port.
// Fail counters and lock bits exist only when ATM_PIN_LOCKOUT_EN is defined.
module atm_account_table #(
  parameter int balance_width = 20,
  parameter int NUM_ACCOUNTS  = 8,
  parameter int ID_W          = 3,
  parameter int PIN_W         = 16,
  parameter int MAX_FAIL      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     wr_pin_en,
  input  logic [ID_W-1:0]          wr_id,
  input  logic [PIN_W-1:0]         wr_pin,
  input  logic [balance_width-1:0] wr_balance,
`ifdef ATM_PIN_LOCKOUT_EN
  input  logic                     fail_upd,
  input  logic                     fail_hit,
  output logic                     rd_locked,
`endif
  input  logic [ID_W-1:0]          rd_id,
  output logic                     rd_in_range,
  output logic [PIN_W-1:0]         rd_pin,
  output logic [balance_width-1:0] rd_balance
);

  if ((1 << ID_W) < NUM_ACCOUNTS) begin : g_bad_id_w
    $error("ID_W too narrow for NUM_ACCOUNTS");
  end
  if (MAX_FAIL < 1) begin : g_bad_max_fail
    $error("MAX_FAIL must be at least 1");
  end

  logic [PIN_W-1:0]         pin_q [NUM_ACCOUNTS];
  logic [balance_width-1:0] bal_q [NUM_ACCOUNTS];
  logic                     wr_in_range;

  assign wr_in_range = {1'b0, wr_id} < (ID_W+1)'(NUM_ACCOUNTS);
  assign rd_in_range = {1'b0, rd_id} < (ID_W+1)'(NUM_ACCOUNTS);
  assign rd_pin      = rd_in_range ? pin_q[rd_id] : '0;
  assign rd_balance  = rd_in_range ? bal_q[rd_id] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        pin_q[i] <= '0;
        bal_q[i] <= '0;
      end
    end else if (wr_en && wr_in_range) begin
      bal_q[wr_id] <= wr_balance;
      if (wr_pin_en) pin_q[wr_id] <= wr_pin;
    end
  end

`ifdef ATM_PIN_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  logic [FW-1:0] fail_q [NUM_ACCOUNTS];
  logic          lock_q [NUM_ACCOUNTS];

  assign rd_locked = rd_in_range ? lock_q[rd_id] : 1'b0;

  // Provisioning unlocks; the counter saturates at MAX_FAIL once locked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        fail_q[i] <= '0;
        lock_q[i] <= 1'b0;
      end
    end else if (wr_en && wr_pin_en && wr_in_range) begin
      fail_q[wr_id] <= '0;
      lock_q[wr_id] <= 1'b0;
    end else if (fail_upd && rd_in_range) begin
      if (fail_hit) begin
        fail_q[rd_id] <= '0;
      end else if (fail_q[rd_id] >= FW'(MAX_FAIL - 1)) begin
        fail_q[rd_id] <= FW'(MAX_FAIL);
        lock_q[rd_id] <= 1'b1;
      end else begin
        fail_q[rd_id] <= fail_q[rd_id] + FW'(1);
      end
    end
  end
`endif

endmodule

// File: rtl/atm_pin_account_unit.sv
// PIN collection/compare stage feeding the ATM control FSM; owns the account table.
// Optional per-account lockout is enabled by defining ATM_PIN_LOCKOUT_EN.
module atm_pin_account_unit
  import atm_pkg::*;
#(
  parameter int balance_width = BALANCE_W_DEFAULT,
  parameter int NUM_ACCOUNTS  = 8,
  parameter int ID_W          = 3,
  parameter int PIN_DIGITS    = 4,
  parameter int MAX_FAIL      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      card_in,
  input  logic [ID_W-1:0]           card_id,
  input  logic                      card_eject,
  input  logic                      digit_valid,
  input  logic [3:0]                digit,
  input  logic                      bal_wr_en,
  input  logic [balance_width-1:0]  bal_wr_data,
  input  logic                      prog_en,
  input  logic [ID_W-1:0]           prog_id,
  input  logic [4*PIN_DIGITS-1:0]   prog_pin,
  input  logic [balance_width-1:0]  prog_balance,
  output logic                      pin_done,
  output logic                      wrong_psw,
  output logic [balance_width-1:0]  current_balance,
  output logic                      session_active,
  output logic                      busy,
`ifdef ATM_PIN_LOCKOUT_EN
  output logic                      account_locked,
`endif
  output logic [2:0]                fsm_state
);

  localparam int PIN_W = 4 * PIN_DIGITS;
  localparam int CNT_W = $clog2(PIN_DIGITS + 1);

  pin_state_t                state, state_next;
  logic [ID_W-1:0]           cur_id;
  logic [PIN_W-1:0]          shift_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      bad_q;
  logic                      load_pending;
  logic                      eject_now;
  logic                      accept_card;
  logic                      mismatch;
  logic                      tbl_wr_en;
  logic                      rd_in_range;
  logic [PIN_W-1:0]          rd_pin;
  logic [balance_width-1:0]  rd_balance;
  logic                      locked_now;

  assign eject_now   = card_eject && (state != ST_IDLE);
  assign accept_card = card_in && (state == ST_IDLE);
  assign tbl_wr_en   = ((state == ST_IDLE) && prog_en) || ((state == ST_SESSION) && bal_wr_en);

  atm_account_table #(
    .balance_width(balance_width),
    .NUM_ACCOUNTS (NUM_ACCOUNTS),
    .ID_W         (ID_W),
    .PIN_W        (PIN_W),
    .MAX_FAIL     (MAX_FAIL)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (tbl_wr_en),
    .wr_pin_en  (state == ST_IDLE),
    .wr_id      ((state == ST_IDLE) ? prog_id : cur_id),
    .wr_pin     (prog_pin),
    .wr_balance ((state == ST_IDLE) ? prog_balance : bal_wr_data),
`ifdef ATM_PIN_LOCKOUT_EN
    .fail_upd   ((state == ST_COMPARE) && !eject_now),
    .fail_hit   (!mismatch),
    .rd_locked  (locked_now),
`endif
    .rd_id      (cur_id),
    .rd_in_range(rd_in_range),
    .rd_pin     (rd_pin),
    .rd_balance (rd_balance)
  );

`ifdef ATM_PIN_LOCKOUT_EN
  assign account_locked = (state != ST_IDLE) && locked_now;
`else
  assign locked_now = 1'b0;
`endif

  assign mismatch       = bad_q || !rd_in_range || (shift_q != rd_pin) || locked_now;
  assign session_active = (state == ST_SESSION);
  assign busy           = (state != ST_IDLE);
  assign fsm_state      = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (card_in) state_next = ST_COLLECT;
      ST_COLLECT: if (digit_valid && (cnt_q == CNT_W'(PIN_DIGITS - 1))) state_next = ST_COMPARE;
      ST_COMPARE: state_next = ST_RESULT;
      ST_RESULT:  state_next = wrong_psw ? ST_COLLECT : ST_SESSION;
      ST_SESSION: state_next = ST_SESSION;
      default:    state_next = ST_IDLE;
    endcase
    if (eject_now) state_next = ST_IDLE;
  end

  // The table write for a commit lands on the same edge as the eject, so
  // clearing current_balance here loses nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_id          <= '0;
      shift_q         <= '0;
      cnt_q           <= '0;
      bad_q           <= 1'b0;
      load_pending    <= 1'b0;
      pin_done        <= 1'b0;
      wrong_psw       <= 1'b0;
      current_balance <= '0;
    end else begin
      pin_done     <= 1'b0;
      load_pending <= accept_card;
      if (accept_card) cur_id <= card_id;
      if (eject_now) begin
        shift_q         <= '0;
        cnt_q           <= '0;
        bad_q           <= 1'b0;
        wrong_psw       <= 1'b0;
        current_balance <= '0;
      end else begin
        case (state)
          ST_COLLECT: if (digit_valid) begin
            shift_q <= {shift_q[PIN_W-5:0], digit};
            cnt_q   <= cnt_q + CNT_W'(1);
            if (digit > BCD_MAX) bad_q <= 1'b1;
          end
          ST_COMPARE: begin
            pin_done  <= 1'b1;
            wrong_psw <= mismatch;
          end
          ST_RESULT: begin
            shift_q <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
          end
          default: ;
        endcase
        if (load_pending)                             current_balance <= rd_balance;
        else if ((state == ST_SESSION) && bal_wr_en)  current_balance <= bal_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_atm_pin_account_unit.sv
// Directed and randomized bench for atm_pin_account_unit against an account-level model.
module tb_atm_pin_account_unit;

  localparam int BW   = 20;
  localparam int NACC = 6;
  localparam int IDW  = 3;
  localparam int ND   = 4;
  localparam int MAXF = 3;
`ifdef ATM_PIN_LOCKOUT_EN
  localparam bit LOCKOUT_ON = 1'b1;
`else
  localparam bit LOCKOUT_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            card_in = 1'b0;
  logic [IDW-1:0]  card_id = '0;
  logic            card_eject = 1'b0;
  logic            digit_valid = 1'b0;
  logic [3:0]      digit = '0;
  logic            bal_wr_en = 1'b0;
  logic [BW-1:0]   bal_wr_data = '0;
  logic            prog_en = 1'b0;
  logic [IDW-1:0]  prog_id = '0;
  logic [4*ND-1:0] prog_pin = '0;
  logic [BW-1:0]   prog_balance = '0;
  logic            pin_done;
  logic            wrong_psw;
  logic [BW-1:0]   current_balance;
  logic            session_active;
  logic            busy;
  logic [2:0]      fsm_state;
`ifdef ATM_PIN_LOCKOUT_EN
  logic            account_locked;
`endif

  atm_pin_account_unit #(
    .balance_width(BW), .NUM_ACCOUNTS(NACC), .ID_W(IDW), .PIN_DIGITS(ND), .MAX_FAIL(MAXF)
  ) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_id(card_id), .card_eject(card_eject),
    .digit_valid(digit_valid), .digit(digit), .bal_wr_en(bal_wr_en), .bal_wr_data(bal_wr_data),
    .prog_en(prog_en), .prog_id(prog_id), .prog_pin(prog_pin), .prog_balance(prog_balance),
    .pin_done(pin_done), .wrong_psw(wrong_psw), .current_balance(current_balance),
    .session_active(session_active), .busy(busy),
`ifdef ATM_PIN_LOCKOUT_EN
    .account_locked(account_locked),
`endif
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // account-level reference model
  logic [BW-1:0]   bal_m  [8];
  logic [4*ND-1:0] pin_m  [8];
  int              fail_m [8];
  bit              lock_m [8];
  int              cur_id_m = 0;
  bit              in_session = 1'b0;
  logic [0:0]      exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_bal(input int id);
    return (id < NACC) ? bal_m[id] : '0;
  endfunction

  function automatic logic [4*ND-1:0] rand_pin();
    logic [4*ND-1:0] p;
    for (int i = 0; i < ND; i++) p[i*4 +: 4] = 4'($urandom_range(0, 9));
    return p;
  endfunction

  function automatic bit model_mismatch(input int id, input logic [4*ND-1:0] typed);
    bit bad = 1'b0;
    for (int i = 0; i < ND; i++) if (typed[i*4 +: 4] > 4'd9) bad = 1'b1;
    if (id >= NACC) return 1'b1;
    if (LOCKOUT_ON && lock_m[id]) return 1'b1;
    return bad || (typed != pin_m[id]);
  endfunction

  // driver tasks
  task automatic prog(input int id, input logic [4*ND-1:0] pin, input logic [BW-1:0] bal);
    prog_en = 1'b1; prog_id = IDW'(id); prog_pin = pin; prog_balance = bal;
    tick();
    prog_en = 1'b0;
    if (id < NACC) begin
      pin_m[id] = pin; bal_m[id] = bal; fail_m[id] = 0; lock_m[id] = 1'b0;
    end
  endtask

  task automatic insert(input int id);
    card_in = 1'b1; card_id = IDW'(id);
    tick();
    card_in = 1'b0;
    cur_id_m = id;
    chk("busy_after_card", busy, 1);
    tick();
    chk("load_balance", current_balance, exp_bal(id));
`ifdef ATM_PIN_LOCKOUT_EN
    chk("locked_on_insert", account_locked, (id < NACC) ? lock_m[id] : 1'b0);
`endif
  endtask

  task automatic enter_pin(input logic [4*ND-1:0] typed);
    bit exp_w;
    exp_w = model_mismatch(cur_id_m, typed);
    exp_q.push_back(exp_w);
    for (int i = ND - 1; i >= 0; i--) begin
      digit_valid = 1'b1; digit = typed[i*4 +: 4];
      tick();
    end
    digit_valid = 1'b0;
    chk("pin_done_early", pin_done, 0);
    tick();
    chk("pin_done", pin_done, 1);
    chk("wrong_psw", wrong_psw, exp_q.pop_front());
    tick();
    chk("pin_done_clear", pin_done, 0);
    chk("session_active", session_active, !exp_w);
    if (LOCKOUT_ON && cur_id_m < NACC) begin
      if (exp_w) begin
        fail_m[cur_id_m]++;
        if (fail_m[cur_id_m] >= MAXF) lock_m[cur_id_m] = 1'b1;
      end else begin
        fail_m[cur_id_m] = 0;
      end
    end
    if (!exp_w) in_session = 1'b1;
  endtask

  task automatic commit(input logic [BW-1:0] v);
    bal_wr_en = 1'b1; bal_wr_data = v;
    tick();
    bal_wr_en = 1'b0;
    bal_m[cur_id_m] = v;
    chk("commit_balance", current_balance, v);
  endtask

  task automatic eject(input bit do_commit, input logic [BW-1:0] v);
    card_eject = 1'b1; bal_wr_en = do_commit; bal_wr_data = v;
    tick();
    card_eject = 1'b0; bal_wr_en = 1'b0;
    if (do_commit && in_session) bal_m[cur_id_m] = v;
    in_session = 1'b0;
    chk("eject_busy", busy, 0);
    chk("eject_session", session_active, 0);
    chk("eject_balance", current_balance, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      bal_m[i] = '0; pin_m[i] = '0; fail_m[i] = 0; lock_m[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_pin_done", pin_done, 0);
    chk("rst_wrong_psw", wrong_psw, 0);
    chk("rst_balance", current_balance, 0);
    chk("rst_session", session_active, 0);
    chk("rst_busy", busy, 0);

    // Reset table: PIN 0000 accepted, balance 0
    insert(3);
    enter_pin(16'h0000);
    eject(1'b0, '0);

    // Basic program / accept
    prog(2, 16'h1234, 20'd500);
    insert(2);
    enter_pin(16'h1234);
    chk("balance_500", current_balance, 20'd500);

    // card_in and prog_en ignored during a session
    card_in = 1'b1; card_id = 3'd4; prog_en = 1'b1; prog_id = 3'd2; prog_pin = 16'h9999;
    tick();
    card_in = 1'b0; prog_en = 1'b0;
    chk("session_kept", session_active, 1);
    chk("session_balance_kept", current_balance, 20'd500);

    // Commit together with eject, then reinsert
    eject(1'b1, 20'd300);
    insert(2);
    chk("balance_300", current_balance, 20'd300);
    enter_pin(16'h1235);
    enter_pin(16'h1234);
    eject(1'b0, '0);

    // Non-BCD digit forces mismatch
    insert(2);
    enter_pin(16'h12A4);
    enter_pin(16'h1234);
    eject(1'b0, '0);

    // Out-of-range id: program ignored, always wrong
    prog(7, 16'h0000, 20'd99);
    insert(7);
    enter_pin(16'h0000);
    eject(1'b0, '0);

    // Eject mid-entry suppresses the result; stray digits in IDLE ignored
    insert(2);
    digit_valid = 1'b1; digit = 4'd1; tick();
    digit = 4'd2; tick();
    digit_valid = 1'b0;
    card_eject = 1'b1; tick(); card_eject = 1'b0;
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_pin_done", pin_done, 0);
      digit_valid = 1'b1; digit = 4'd7;
      tick();
    end
    digit_valid = 1'b0;
    insert(2);
    enter_pin(16'h1234);
    eject(1'b0, '0);

    // Simultaneous program and card insertion on the same id
    prog_en = 1'b1; prog_id = 3'd4; prog_pin = 16'h9876; prog_balance = 20'd777;
    card_in = 1'b1; card_id = 3'd4;
    tick();
    prog_en = 1'b0; card_in = 1'b0;
    pin_m[4] = 16'h9876; bal_m[4] = 20'd777; fail_m[4] = 0; lock_m[4] = 1'b0;
    cur_id_m = 4;
    tick();
    chk("prog_and_card_balance", current_balance, 20'd777);
    enter_pin(16'h9876);
    commit(20'd12345);
    eject(1'b0, '0);

`ifdef ATM_PIN_LOCKOUT_EN
    prog(1, 16'h4321, 20'd50);
    insert(1);
    enter_pin(16'h1111);
    enter_pin(16'h2222);
    enter_pin(16'h3333);
    chk("locked_after_fails", account_locked, 1);
    enter_pin(16'h4321);
    eject(1'b0, '0);
    chk("locked_cleared_on_eject", account_locked, 0);
    prog(1, 16'h4321, 20'd50);
    insert(1);
    chk("unlocked_after_prog", account_locked, 0);
    enter_pin(16'h4321);
    eject(1'b0, '0);
`endif

    // Randomized sessions
    for (int it = 0; it < 30; it++) begin
      int id;
      logic [BW-1:0] v;
      id = int'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) prog(id, rand_pin(), BW'($urandom_range(0, 1048575)));
      insert(id);
      for (int a = 0; a < 3 && !in_session; a++) begin
        if ($urandom_range(0, 1) == 1) enter_pin(pin_m[id]);
        else                           enter_pin(rand_pin());
      end
      v = BW'($urandom_range(0, 1048575));
      if (in_session && $urandom_range(0, 1) == 1) commit(v);
      v = BW'($urandom_range(0, 1048575));
      eject($urandom_range(0, 1) == 1, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
